// File: rtl/chunked_rca_adder.sv
// Multi-cycle ripple-carry adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with the inter-chunk carry held in a register and valid/ready handshakes on both sides.
module chunked_rca_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] b_k;
    logic [CHUNK:0]   sum_ext;
    logic             msb_carry;

    assign base    = 32'(cnt) * CHUNK;
    assign a_k     = a_r[base +: CHUNK];
    assign b_k     = b_r[base +: CHUNK];
    assign sum_ext = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry};
    // Carry into the top bit of the chunk, recovered from its sum bit; on the last chunk this is the carry into the MSB.
    assign msb_carry = sum_ext[CHUNK-1] ^ a_k[CHUNK-1] ^ b_k[CHUNK-1];

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b ^ {WIDTH{sub}};
                        carry <= ci ^ sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s[base +: CHUNK] <= sum_ext[CHUNK-1:0];
                    carry            <= sum_ext[CHUNK];
                    if (cnt == LAST) begin
                        co    <= sum_ext[CHUNK];
                        ovf   <= msb_carry ^ sum_ext[CHUNK];
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_rca_adder.sv
// Self-checking bench for chunked_rca_adder (WIDTH=8, CHUNK=2): directed test-plan cases
// with literal expectations plus randomized operations checked against an arithmetic model.
module tb_chunked_rca_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] s;
    logic       co;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_s;
    logic       exp_co;
    logic       exp_ovf;
    bit         exp_pending = 0;
    bit         busy = 0;

    chunked_rca_adder #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Result packed as {ovf, co, s}, from integer arithmetic on unsigned and signed views.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mci, input logic msub);
        int ua, ub, uc, ur, sa, sb, sr;
        logic [7:0] rs;
        logic rco, rov;
        ua = int'(ma);
        ub = int'(mb);
        uc = int'(mci);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!msub) begin
            ur  = ua + ub + uc;
            rco = (ur >= 256);
            sr  = sa + sb + uc;
        end else begin
            ur  = ua - ub - uc;
            rco = (ur >= 0);
            sr  = sa - sb - uc;
        end
        rs  = ur[7:0];
        rov = (sr > 127) || (sr < -128);
        return {rov, rco, rs};
    endfunction

    always @(negedge clk) begin
        if (busy && !rst)
            chk("busy_in_ready", 32'(in_ready), 32'd0);
        if (out_valid)
            chk("done_result", {22'd0, ovf, co, s}, {22'd0, exp_ovf, exp_co, exp_s});
        if (!exp_pending)
            chk("spurious_valid", 32'(out_valid), 32'd0);
    end

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_op, input logic tci,
                         input logic tsub, input int hold, input bit junk,
                         input bit lit, input logic [9:0] lit_exp);
        int k;
        logic [9:0] m;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta; b = tb_op; ci = tci; sub = tsub; in_valid = 1'b1;
        m = model(ta, tb_op, tci, tsub);
        exp_s = m[7:0]; exp_co = m[8]; exp_ovf = m[9];
        if (lit) chk("model_pin", 32'(m), 32'(lit_exp));
        @(posedge clk);
        exp_pending = 1;
        busy = 1;
        #1;
        if (junk) begin
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!out_valid && k < 20);
        chk("latency", 32'(k), 32'd4);
        if (lit) chk("lit_result", {22'd0, ovf, co, s}, 32'(lit_exp));
        repeat (hold) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        exp_pending = 0;
        busy = 0;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co_ovf", {30'd0, co, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        do_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 0, 1, 10'h010);
        do_op(8'hFF, 8'h01, 1'b1, 1'b0, 0, 0, 1, 10'h101);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1, 0, 1, 10'h280);
        do_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 0, 1, 10'h0FE);
        do_op(8'h80, 8'h01, 1'b0, 1'b1, 0, 0, 1, 10'h37F);
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 3, 1, 1, 10'h046);

        // Reset lands on the edge that would compute chunk 2.
        @(negedge clk);
        a = 8'hA5; b = 8'h3C; ci = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_rst_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_s", 32'(s), 32'd0);
        chk("midrun_rst_co_ovf", {30'd0, co, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (6) @(negedge clk);
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 0, 1, 10'h002);

        for (int i = 0; i < 40; i++)
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), bit'($urandom), 0, 10'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
